// File: rtl/ex_mem_stage_pkg.sv
// Shared pipeline types: branch kinds, memory operation kinds and ALU flag positions.
package type_enums;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_EQ   = 4'd1,
        BR_NE   = 4'd2,
        BR_LT   = 4'd3,
        BR_GE   = 4'd4,
        BR_LTU  = 4'd5,
        BR_GEU  = 4'd6,
        BR_JAL  = 4'd7,
        BR_JALR = 4'd8
    } br_t;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        LB       = 4'd1,
        LH       = 4'd2,
        LW       = 4'd3,
        LBU      = 4'd4,
        LHU      = 4'd5,
        SB       = 4'd6,
        SH       = 4'd7,
        SW       = 4'd8
    } mem_op_t;

    localparam int unsigned FLAG_OF = 3;
    localparam int unsigned FLAG_SF = 2;
    localparam int unsigned FLAG_CF = 1;
    localparam int unsigned FLAG_ZF = 0;

    function automatic logic is_jump(input br_t op);
        return (op == BR_JAL) || (op == BR_JALR);
    endfunction

endpackage

// File: rtl/ex_mem_stage_branch_cond.sv
// Branch resolution from ALU flags, assuming the ALU computed rs1 - rs2.
module branch_cond
    import type_enums::*;
(
    input  br_t        i_br_op,
    input  logic [3:0] i_flags,
    output logic       o_taken
);

    logic w_lt;

    assign w_lt = i_flags[FLAG_SF] ^ i_flags[FLAG_OF];

    always_comb begin
        o_taken = 1'b0;
        unique case (i_br_op)
            BR_EQ:   o_taken = i_flags[FLAG_ZF];
            BR_NE:   o_taken = !i_flags[FLAG_ZF];
            BR_LT:   o_taken = w_lt;
            BR_GE:   o_taken = !w_lt;
            BR_LTU:  o_taken = i_flags[FLAG_CF];
            BR_GEU:  o_taken = !i_flags[FLAG_CF];
            BR_JAL,
            BR_JALR: o_taken = 1'b1;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution, fetch redirect and misalignment pulse.
module ex_mem_stage
    import type_enums::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [WIDTH-1:0]      ex_alu_out,
    input  logic [3:0]            ex_flags,
    input  br_t                   ex_br_op,
    input  logic [WIDTH-1:0]      ex_target,
    input  logic [WIDTH-1:0]      ex_pc_plus4,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_we,
    input  mem_op_t               ex_mem_op,
    input  logic [WIDTH-1:0]      ex_store_data,
    input  logic                  flush,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [WIDTH-1:0]      mem_result,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  mem_reg_we,
    output mem_op_t               mem_op,
    output logic [WIDTH-1:0]      mem_store_data,
    output logic                  redirect_valid,
    output logic [WIDTH-1:0]      redirect_pc,
    output logic                  misalign_exc
);

    logic                  w_taken;
    logic                  w_accept;
    logic                  w_misaligned;
    logic                  w_reg_we;
    logic [WIDTH-1:0]      w_result;

    logic                  r_mem_valid;
    logic [WIDTH-1:0]      r_mem_result;
    logic [REG_ADDR_W-1:0] r_mem_rd;
    logic                  r_mem_reg_we;
    mem_op_t               r_mem_op;
    logic [WIDTH-1:0]      r_mem_store_data;
    logic                  r_redirect_valid;
    logic [WIDTH-1:0]      r_redirect_pc;
    logic                  r_misalign_exc;

    branch_cond u_branch_cond (
        .i_br_op (ex_br_op),
        .i_flags (ex_flags),
        .o_taken (w_taken)
    );

    assign ex_ready     = !r_mem_valid || mem_ready;
    assign w_accept     = ex_valid && ex_ready && !flush;
    assign w_misaligned = w_taken && (ex_target[1:0] != 2'b00);
    assign w_result     = is_jump(ex_br_op) ? ex_pc_plus4 : ex_alu_out;
    // x0 is never written, and a faulting jump must not retire its link value
    assign w_reg_we     = ex_reg_we && (ex_rd != '0) && !w_misaligned;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem_valid      <= 1'b0;
            r_mem_result     <= '0;
            r_mem_rd         <= '0;
            r_mem_reg_we     <= 1'b0;
            r_mem_op         <= MEM_NONE;
            r_mem_store_data <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_misalign_exc   <= 1'b0;
        end else begin
            r_redirect_valid <= 1'b0;
            r_misalign_exc   <= 1'b0;
            if (flush) begin
                r_mem_valid <= 1'b0;
            end else if (w_accept) begin
                r_mem_valid      <= 1'b1;
                r_mem_result     <= w_result;
                r_mem_rd         <= ex_rd;
                r_mem_reg_we     <= w_reg_we;
                r_mem_op         <= ex_mem_op;
                r_mem_store_data <= ex_store_data;
                r_misalign_exc   <= w_misaligned;
                if (w_taken && !w_misaligned) begin
                    r_redirect_valid <= 1'b1;
                    r_redirect_pc    <= ex_target;
                end
            end else if (mem_ready) begin
                r_mem_valid <= 1'b0;
            end
        end
    end

    assign mem_valid      = r_mem_valid;
    assign mem_result     = r_mem_result;
    assign mem_rd         = r_mem_rd;
    assign mem_reg_we     = r_mem_reg_we;
    assign mem_op         = r_mem_op;
    assign mem_store_data = r_mem_store_data;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign misalign_exc   = r_misalign_exc;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: vector table with scoreboard plus hand-written stall/flush/reset sequences.
module tb_ex_mem_stage;
    import type_enums::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alu_out;
    logic [3:0]  ex_flags;
    br_t         ex_br_op;
    logic [31:0] ex_target;
    logic [31:0] ex_pc_plus4;
    logic [4:0]  ex_rd;
    logic        ex_reg_we;
    mem_op_t     ex_mem_op;
    logic [31:0] ex_store_data;
    logic        flush;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_result;
    logic [4:0]  mem_rd;
    logic        mem_reg_we;
    mem_op_t     mem_op;
    logic [31:0] mem_store_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_exc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(.WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_alu_out     (ex_alu_out),
        .ex_flags       (ex_flags),
        .ex_br_op       (ex_br_op),
        .ex_target      (ex_target),
        .ex_pc_plus4    (ex_pc_plus4),
        .ex_rd          (ex_rd),
        .ex_reg_we      (ex_reg_we),
        .ex_mem_op      (ex_mem_op),
        .ex_store_data  (ex_store_data),
        .flush          (flush),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_result     (mem_result),
        .mem_rd         (mem_rd),
        .mem_reg_we     (mem_reg_we),
        .mem_op         (mem_op),
        .mem_store_data (mem_store_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign_exc   (misalign_exc)
    );

    typedef struct {
        br_t         br;
        logic [3:0]  flags;
        logic [31:0] target;
        logic [31:0] pc4;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        we;
        mem_op_t     mop;
        logic [31:0] sd;
        logic        e_redir;
        logic        e_mis;
        logic [31:0] e_res;
        logic        e_we;
    } vec_t;

    typedef struct {
        logic        redir;
        logic        mis;
        logic [31:0] rpc;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
        mem_op_t     mop;
        logic [31:0] sd;
    } exp_t;

    localparam int NV = 15;
    vec_t vecs [NV];
    exp_t sb [$];
    exp_t e;
    exp_t g;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        ex_br_op      = v.br;
        ex_flags      = v.flags;
        ex_target     = v.target;
        ex_pc_plus4   = v.pc4;
        ex_alu_out    = v.alu;
        ex_rd         = v.rd;
        ex_reg_we     = v.we;
        ex_mem_op     = v.mop;
        ex_store_data = v.sd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          br       flags    target        pc4           alu           rd  we mop      sd            redir mis res           we
        vecs[0]  = '{BR_EQ,   4'b0001, 32'h0000_0100, 32'h0000_0004, 32'h0000_0000, 5'd5, 1'b0, MEM_NONE, 32'h0,        1'b1, 1'b0, 32'h0000_0000, 1'b0};
        vecs[1]  = '{BR_EQ,   4'b0000, 32'h0000_0100, 32'h0000_0008, 32'h0000_0003, 5'd5, 1'b0, MEM_NONE, 32'h0,        1'b0, 1'b0, 32'h0000_0003, 1'b0};
        vecs[2]  = '{BR_NE,   4'b0000, 32'h0000_0200, 32'h0000_000C, 32'h0000_0003, 5'd0, 1'b0, MEM_NONE, 32'h0,        1'b1, 1'b0, 32'h0000_0003, 1'b0};
        vecs[3]  = '{BR_LT,   4'b0100, 32'h0000_0300, 32'h0000_0010, 32'hFFFF_FFFE, 5'd0, 1'b0, MEM_NONE, 32'h0,        1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0};
        vecs[4]  = '{BR_LTU,  4'b0100, 32'h0000_0300, 32'h0000_0014, 32'hFFFF_FFFE, 5'd0, 1'b0, MEM_NONE, 32'h0,        1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0};
        vecs[5]  = '{BR_GE,   4'b1100, 32'h0000_0040, 32'h0000_0018, 32'h8000_0000, 5'd0, 1'b0, MEM_NONE, 32'h0,        1'b1, 1'b0, 32'h8000_0000, 1'b0};
        vecs[6]  = '{BR_GEU,  4'b0010, 32'h0000_0044, 32'h0000_001C, 32'hFFFF_FFFF, 5'd0, 1'b0, MEM_NONE, 32'h0,        1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0};
        vecs[7]  = '{BR_LTU,  4'b0010, 32'h0000_0044, 32'h0000_0020, 32'hFFFF_FFFF, 5'd0, 1'b0, MEM_NONE, 32'h0,        1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0};
        vecs[8]  = '{BR_NONE, 4'b0001, 32'h0000_0100, 32'h0000_0024, 32'h0000_1234, 5'd3, 1'b1, MEM_NONE, 32'h0,        1'b0, 1'b0, 32'h0000_1234, 1'b1};
        vecs[9]  = '{BR_JAL,  4'b0000, 32'h0000_0080, 32'h0000_0024, 32'h0000_0555, 5'd1, 1'b1, MEM_NONE, 32'h0,        1'b1, 1'b0, 32'h0000_0024, 1'b1};
        vecs[10] = '{BR_JAL,  4'b0000, 32'h0000_0102, 32'h0000_0010, 32'h0000_0555, 5'd2, 1'b1, MEM_NONE, 32'h0,        1'b0, 1'b1, 32'h0000_0010, 1'b0};
        vecs[11] = '{BR_JALR, 4'b0000, 32'h0000_0203, 32'h0000_0014, 32'h0000_0203, 5'd4, 1'b1, MEM_NONE, 32'h0,        1'b0, 1'b1, 32'h0000_0014, 1'b0};
        vecs[12] = '{BR_NONE, 4'b0000, 32'h0000_0000, 32'h0000_0030, 32'h0000_0077, 5'd0, 1'b1, MEM_NONE, 32'h0,        1'b0, 1'b0, 32'h0000_0077, 1'b0};
        vecs[13] = '{BR_NONE, 4'b0000, 32'h0000_0000, 32'h0000_0034, 32'h0000_1000, 5'd7, 1'b1, LW,       32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_1000, 1'b1};
        vecs[14] = '{BR_GE,   4'b0100, 32'h0000_0500, 32'h0000_0038, 32'hFFFF_FFFE, 5'd0, 1'b0, MEM_NONE, 32'h0,        1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0};

        rst_n = 1'b0; flush = 1'b0; mem_ready = 1'b1; ex_valid = 1'b1;
        drive(vecs[9]);

        // Reset held two cycles with a taken jump presented
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
            chk("rst_redirect", {31'b0, redirect_valid}, 32'd0);
            chk("rst_misalign", {31'b0, misalign_exc}, 32'd0);
            chk("rst_result", mem_result, 32'd0);
        end
        ex_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("post_rst_mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("post_rst_redirect", {31'b0, redirect_valid}, 32'd0);

        // Table: accept each vector, then an idle cycle for pulse width and drain
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            ex_valid = 1'b1;
            e.redir = vecs[i].e_redir;
            e.mis   = vecs[i].e_mis;
            e.rpc   = vecs[i].target;
            e.res   = vecs[i].e_res;
            e.rd    = vecs[i].rd;
            e.we    = vecs[i].e_we;
            e.mop   = vecs[i].mop;
            e.sd    = vecs[i].sd;
            sb.push_back(e);
            step();
            ex_valid = 1'b0;
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
            end else begin
                g = sb.pop_front();
                chk($sformatf("v%0d_mem_valid", i), {31'b0, mem_valid}, 32'd1);
                chk($sformatf("v%0d_redirect", i), {31'b0, redirect_valid}, {31'b0, g.redir});
                chk($sformatf("v%0d_misalign", i), {31'b0, misalign_exc}, {31'b0, g.mis});
                if (g.redir) chk($sformatf("v%0d_redirect_pc", i), redirect_pc, g.rpc);
                chk($sformatf("v%0d_result", i), mem_result, g.res);
                chk($sformatf("v%0d_rd", i), {27'b0, mem_rd}, {27'b0, g.rd});
                chk($sformatf("v%0d_reg_we", i), {31'b0, mem_reg_we}, {31'b0, g.we});
                chk($sformatf("v%0d_mem_op", i), {28'b0, mem_op}, {28'b0, g.mop});
                chk($sformatf("v%0d_store_data", i), mem_store_data, g.sd);
            end
            step();
            chk($sformatf("v%0d_idle_redirect", i), {31'b0, redirect_valid}, 32'd0);
            chk($sformatf("v%0d_idle_misalign", i), {31'b0, misalign_exc}, 32'd0);
            chk($sformatf("v%0d_idle_mem_valid", i), {31'b0, mem_valid}, 32'd0);
        end

        // Back-to-back: accept replaces the draining instruction
        drive(vecs[8]); ex_valid = 1'b1;
        step();
        drive(vecs[13]);
        step();
        ex_valid = 1'b0;
        chk("b2b_mem_valid", {31'b0, mem_valid}, 32'd1);
        chk("b2b_result", mem_result, 32'h0000_1000);
        chk("b2b_rd", {27'b0, mem_rd}, 32'd7);
        step();

        // Backpressure after an accepted JAL
        drive(vecs[9]); ex_valid = 1'b1; mem_ready = 1'b0;
        step();
        chk("bp_accept_valid", {31'b0, mem_valid}, 32'd1);
        chk("bp_accept_redirect", {31'b0, redirect_valid}, 32'd1);
        chk("bp_accept_pc", redirect_pc, 32'h0000_0080);
        drive(vecs[8]);
        for (int c = 0; c < 3; c++) begin
            chk("bp_ex_ready", {31'b0, ex_ready}, 32'd0);
            step();
            chk("bp_hold_result", mem_result, 32'h0000_0024);
            chk("bp_hold_valid", {31'b0, mem_valid}, 32'd1);
            chk("bp_no_redirect", {31'b0, redirect_valid}, 32'd0);
        end
        ex_valid = 1'b0; mem_ready = 1'b1;
        step();
        chk("bp_drain_valid", {31'b0, mem_valid}, 32'd0);
        chk("bp_drain_redirect", {31'b0, redirect_valid}, 32'd0);

        // Flush on the cycle a taken JALR is presented
        drive(vecs[9]); ex_br_op = BR_JALR; ex_valid = 1'b1; flush = 1'b1;
        step();
        ex_valid = 1'b0; flush = 1'b0;
        chk("flush_mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("flush_redirect", {31'b0, redirect_valid}, 32'd0);
        chk("flush_misalign", {31'b0, misalign_exc}, 32'd0);

        // Flush kills a held instruction
        drive(vecs[8]); ex_valid = 1'b1; mem_ready = 1'b0;
        step();
        ex_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_held_valid", {31'b0, mem_valid}, 32'd0);

        // Reset during a stall discards the held jump with no pulse after
        drive(vecs[9]); ex_valid = 1'b1;
        step();
        ex_valid = 1'b0;
        step();
        chk("rs_stall_valid", {31'b0, mem_valid}, 32'd1);
        rst_n = 1'b0;
        step();
        chk("rs_mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("rs_result", mem_result, 32'd0);
        rst_n = 1'b1; mem_ready = 1'b1;
        step();
        chk("rs_after_redirect", {31'b0, redirect_valid}, 32'd0);
        chk("rs_after_valid", {31'b0, mem_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
